// File: rtl/fixed_point_subtractor_serial.sv
// Digit-serial unsigned fixed-point subtractor (A - B), fractional LSB digit first.
// Optional macro FXP_SUB_SAT_EN: clamp negative results to zero (negative flag still reports borrow).

module fxs_digit_cell #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] diff,
    output logic               borrow_out
);
    // One extra bit catches the borrow; the worst case 0 - max - 1 still fits.
    logic [DIGIT_W:0] wide;

    assign wide       = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, borrow_in};
    assign diff       = wide[DIGIT_W-1:0];
    assign borrow_out = wide[DIGIT_W];
endmodule

module fixed_point_subtractor_serial #(
    parameter int INT_W   = 8,
    parameter int FRAC_W  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  a_integer,
    input  logic [FRAC_W-1:0] a_fractional,
    input  logic [INT_W-1:0]  b_integer,
    input  logic [FRAC_W-1:0] b_fractional,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W:0]    result_integer,
    output logic [FRAC_W-1:0] result_fractional,
    output logic              negative
);
    localparam int W      = INT_W + FRAC_W;
    localparam int DIGITS = W / DIGIT_W;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t                           state;
    logic [DIGITS-1:0][DIGIT_W-1:0]   a_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]   b_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]   diff_q;
    logic [DIGITS-1:0][DIGIT_W-1:0]   diff_next;
    logic                             borrow;
    logic [IDX_W-1:0]                 idx;

    logic [DIGIT_W-1:0]               digit_diff;
    logic                             borrow_out;
    logic                             last_digit;
    logic [W:0]                       full_word;

    fxs_digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
        .a          (a_q[idx]),
        .b          (b_q[idx]),
        .borrow_in  (borrow),
        .diff       (digit_diff),
        .borrow_out (borrow_out)
    );

    always_comb begin
        diff_next      = diff_q;
        diff_next[idx] = digit_diff;
    end

    // Final borrow becomes the sign bit of the INT_W+1.FRAC_W two's-complement word.
    assign full_word  = {borrow_out, diff_next};
    assign last_digit = (idx == IDX_W'(DIGITS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            a_q               <= '0;
            b_q               <= '0;
            diff_q            <= '0;
            borrow            <= 1'b0;
            idx               <= '0;
            result_integer    <= '0;
            result_fractional <= '0;
            negative          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= {a_integer, a_fractional};
                        b_q    <= {b_integer, b_fractional};
                        diff_q <= '0;
                        borrow <= 1'b0;
                        idx    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    diff_q <= diff_next;
                    borrow <= borrow_out;
                    idx    <= idx + IDX_W'(1);
                    if (last_digit) begin
                        negative <= borrow_out;
`ifdef FXP_SUB_SAT_EN
                        if (borrow_out) begin
                            result_integer    <= '0;
                            result_fractional <= '0;
                        end else begin
                            result_integer    <= full_word[W:FRAC_W];
                            result_fractional <= full_word[FRAC_W-1:0];
                        end
`else
                        result_integer    <= full_word[W:FRAC_W];
                        result_fractional <= full_word[FRAC_W-1:0];
`endif
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_subtractor_serial.sv
// Directed bench for fixed_point_subtractor_serial: hand-computed vectors, latency,
// hold/back-pressure, single-cycle pulse and mid-operation reset.

module tb_fixed_point_subtractor_serial;
`ifdef FXP_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_integer = '0;
    logic [3:0] a_fractional = '0;
    logic [7:0] b_integer = '0;
    logic [3:0] b_fractional = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] result_integer;
    logic [3:0] result_fractional;
    logic       negative;

    int vectors = 0;
    int miscompares = 0;

    fixed_point_subtractor_serial dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .a_integer         (a_integer),
        .a_fractional      (a_fractional),
        .b_integer         (b_integer),
        .b_fractional      (b_fractional),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result_integer    (result_integer),
        .result_fractional (result_fractional),
        .negative          (negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid and return the number of edges taken (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
    endtask

    task automatic drive(input logic [7:0] ai, input logic [3:0] af,
                         input logic [7:0] bi, input logic [3:0] bf);
        a_integer = ai; a_fractional = af;
        b_integer = bi; b_fractional = bf;
    endtask

    // Full transaction starting in IDLE at posedge+1; neg cases clamp when SAT is built in.
    task automatic run_op(input string tag,
                          input logic [7:0] ai, input logic [3:0] af,
                          input logic [7:0] bi, input logic [3:0] bf,
                          input logic [8:0] ei, input logic [3:0] ef, input logic en);
        int n;
        logic [8:0] xi;
        logic [3:0] xf;
        xi = (SAT && en) ? 9'h000 : ei;
        xf = (SAT && en) ? 4'h0 : ef;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        drive(ai, af, bi, bf);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, ".in_ready_calc"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        check({tag, ".latency"}, 32'(n), 32'd3);
        check({tag, ".int"}, 32'(result_integer), 32'(xi));
        check({tag, ".frac"}, 32'(result_fractional), 32'(xf));
        check({tag, ".neg"}, 32'(negative), 32'(en));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen;

        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.int", 32'(result_integer), 32'd0);
        check("rst.frac", 32'(result_fractional), 32'd0);
        check("rst.neg", 32'(negative), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst.in_ready", 32'(in_ready), 32'd1);

        run_op("v2p5_1p10", 8'd2, 4'd5, 8'd1, 4'd10, 9'd0, 4'd11, 1'b0);
        run_op("v3p0_0p1", 8'd3, 4'd0, 8'd0, 4'd1, 9'd2, 4'd15, 1'b0);
        run_op("v1p0_2p0", 8'd1, 4'd0, 8'd2, 4'd0, 9'h1FF, 4'd0, 1'b1);
        run_op("v0_max", 8'd0, 4'd0, 8'd255, 4'd15, 9'h100, 4'd1, 1'b1);
        run_op("vmax_0", 8'd255, 4'd15, 8'd0, 4'd0, 9'd255, 4'd15, 1'b0);
        run_op("veq", 8'd100, 4'd7, 8'd100, 4'd7, 9'd0, 4'd0, 1'b0);
        run_op("v200p3_57p9", 8'd200, 4'd3, 8'd57, 4'd9, 9'd142, 4'd10, 1'b0);

        // Back-pressure: hold for 5 cycles while in_valid toggles with junk operands.
        drive(8'd8, 4'd0, 8'd3, 4'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("hold.latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            drive(8'(i * 37 + 1), 4'(i), 8'(i * 11), 4'(15 - i));
            step();
            check("hold.out_valid", 32'(out_valid), 32'd1);
            check("hold.in_ready", 32'(in_ready), 32'd0);
            check("hold.int", 32'(result_integer), 32'd5);
            check("hold.frac", 32'(result_fractional), 32'd0);
            check("hold.neg", 32'(negative), 32'd0);
        end
        drive(8'd50, 4'd4, 8'd20, 4'd8);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hs.out_valid", 32'(out_valid), 32'd0);
        check("hs.in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("op2.in_ready", 32'(in_ready), 32'd0);
        wait_valid(n);
        check("op2.latency", 32'(n), 32'd3);
        check("op2.int", 32'(result_integer), 32'd29);
        check("op2.frac", 32'(result_fractional), 32'd12);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // out_ready already high when HOLD is entered: single-cycle pulse.
        drive(8'd10, 4'd1, 8'd4, 4'd2);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("pulse.latency", 32'(n), 32'd3);
        check("pulse.int", 32'(result_integer), 32'd5);
        check("pulse.frac", 32'(result_fractional), 32'd15);
        step();
        check("pulse.drop", 32'(out_valid), 32'd0);
        check("pulse.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Reset mid-CALC: operation abandoned, previously loaded result cleared.
        drive(8'd1, 4'd0, 8'd2, 4'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", 32'(out_valid), 32'd0);
        check("mrst.int", 32'(result_integer), 32'd0);
        check("mrst.frac", 32'(result_fractional), 32'd0);
        check("mrst.neg", 32'(negative), 32'd0);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("mrst.no_valid", 32'(seen), 32'd0);
        run_op("post_rst", 8'd20, 4'd3, 8'd7, 4'd5, 9'd12, 4'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
